// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad scan state encoding, widths and the
// active-low one-hot column/digit-common select used by keypad and FND drive.
package calc_pkg;

  localparam int KEY_W = 4;
  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } scan_state_e;

  function automatic logic [COL_W-1:0] COL_SEL(input logic [IDX_W-1:0] idx);
    COL_SEL = ~(COL_W'(1) << idx);
  endfunction

endpackage

// File: rtl/clk_div.sv
// Free-running divider producing a one-cycle tick every REF_CNT clocks.
module clk_div #(
  parameter int REF_CNT = 100_000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int CW = (REF_CNT > 1) ? $clog2(REF_CNT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(REF_CNT - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes columns, synchronises rows and debounces
// one key at a time into a valid pulse plus a held level.
module keypad_scan
  import calc_pkg::*;
#(
  parameter int SCAN_CNT       = 100_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROW_W-1:0] row_n,
  output logic [COL_W-1:0] col_n,
  output logic [KEY_W-1:0] key_code,
  output logic             key_valid,
  output logic             key_held
);

  localparam logic [7:0] DS = 8'(DEBOUNCE_SCANS);

  logic             tick;
  logic [ROW_W-1:0] row_meta_q, row_s_q;
  scan_state_e      state_q, state_d;
  logic [IDX_W-1:0] col_idx_q, col_idx_d;
  logic [IDX_W-1:0] cand_q, cand_d;
  logic [7:0]       stab_q, stab_d;
  logic [7:0]       rel_q, rel_d;
  logic [KEY_W-1:0] code_q, code_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic             hit;
  logic [IDX_W-1:0] row_idx;

  clk_div #(.REF_CNT(SCAN_CNT)) u_div (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  // Rows idle high, so the synchroniser resets to "no key" rather than zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '1;
      row_s_q    <= '1;
    end else begin
      row_meta_q <= row_n;
      row_s_q    <= row_meta_q;
    end
  end

  always_comb begin
    hit     = |(~row_s_q);
    row_idx = '0;
    for (int i = ROW_W - 1; i >= 0; i--) begin
      if (!row_s_q[i]) row_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    col_idx_d = col_idx_q;
    cand_d    = cand_q;
    stab_d    = stab_q;
    rel_d     = rel_q;
    code_d    = code_q;
    valid_d   = 1'b0;
    held_d    = held_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            cand_d = row_idx;
            stab_d = 8'd1;
            if (DS == 8'd1) begin
              code_d  = {row_idx, col_idx_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              stab_d  = '0;
              state_d = PRESSED;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && row_idx == cand_q) begin
            stab_d = stab_q + 8'd1;
            if (stab_q + 8'd1 == DS) begin
              code_d  = {cand_q, col_idx_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              stab_d  = '0;
              state_d = PRESSED;
            end
          end else begin
            stab_d    = '0;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = IDLE;
          end
        end
        PRESSED: begin
          if (!hit) begin
            rel_d = 8'd1;
            if (DS == 8'd1) begin
              rel_d     = '0;
              held_d    = 1'b0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = IDLE;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (hit) begin
            rel_d   = '0;
            state_d = PRESSED;
          end else begin
            rel_d = rel_q + 8'd1;
            if (rel_q + 8'd1 == DS) begin
              rel_d     = '0;
              held_d    = 1'b0;
              col_idx_d = col_idx_q + 2'd1;
              state_d   = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      col_idx_q <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      rel_q     <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_idx_q <= col_idx_d;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      rel_q     <= rel_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col_n     = COL_SEL(col_idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Self-checking bench: two scanners (debounce 3 and 1) driven by modelled keypad
// matrices, checked every cycle against a tick-level behavioural model.
module tb_keypad_scan;
  import calc_pkg::*;

  localparam int SCAN = 4;
  localparam logic [3:0] COL_SEQ [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  typedef struct packed {
    bit         live;
    int         n;
    logic [3:0] h1;
    logic [3:0] h2;
    int         col;
    bit         locked;
    int         cand;
    int         streak;
    int         relStreak;
    logic [3:0] code;
    bit         valid;
    bit         held;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] rowNA, colNA, codeA, rowNB, colNB, codeB;
  logic validA, heldA, validB, heldB;
  bit pressA [4][4];
  bit pressB [4][4];
  model_t mA = '0;
  model_t mB = '0;
  int compared = 0;
  int mismatched = 0;
  int pulsesA = 0;
  int base;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_CNT(SCAN), .DEBOUNCE_SCANS(3)) dutA (
    .clk(clk), .rst(rst), .row_n(rowNA), .col_n(colNA),
    .key_code(codeA), .key_valid(validA), .key_held(heldA)
  );

  keypad_scan #(.SCAN_CNT(SCAN), .DEBOUNCE_SCANS(1)) dutB (
    .clk(clk), .rst(rst), .row_n(rowNB), .col_n(colNB),
    .key_code(codeB), .key_valid(validB), .key_held(heldB)
  );

  // Keypad matrix: a pressed key shorts its row low while its column is strobed.
  always_comb begin
    rowNA = 4'hF;
    rowNB = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressA[r][c] && colNA[c] === 1'b0) rowNA[r] = 1'b0;
        if (pressB[r][c] && colNB[c] === 1'b0) rowNB[r] = 1'b0;
      end
    end
  end

  // Tick-level view: per scan tick, track the winning row's streak and the release streak.
  function automatic model_t modelStep(model_t m, logic rstIn, logic [3:0] rowIn, int ds);
    logic [3:0] rs;
    int win;
    bit tick;
    if (rstIn) begin
      m = '0;
      m.live = 1'b1;
      m.h1 = 4'hF;
      m.h2 = 4'hF;
      m.cand = -1;
      return m;
    end
    if (!m.live) return m;
    rs = m.h2;
    m.h2 = m.h1;
    m.h1 = rowIn;
    tick = ((m.n % SCAN) == SCAN - 1);
    m.n++;
    m.valid = 1'b0;
    if (tick) begin
      win = -1;
      for (int i = 3; i >= 0; i--) if (rs[i] == 1'b0) win = i;
      if (!m.locked) begin
        if (m.cand < 0) begin
          if (win >= 0) begin
            m.cand = win;
            m.streak = 1;
          end else m.col = (m.col + 1) % 4;
        end else if (win == m.cand) m.streak++;
        else begin
          m.cand = -1;
          m.streak = 0;
          m.col = (m.col + 1) % 4;
        end
        if (m.cand >= 0 && m.streak == ds) begin
          m.code = 4'(m.cand * 4 + m.col);
          m.valid = 1'b1;
          m.held = 1'b1;
          m.locked = 1'b1;
          m.cand = -1;
          m.streak = 0;
        end
      end else begin
        m.relStreak = (win < 0) ? m.relStreak + 1 : 0;
        if (m.relStreak == ds) begin
          m.held = 1'b0;
          m.locked = 1'b0;
          m.relStreak = 0;
          m.col = (m.col + 1) % 4;
        end
      end
    end
    return m;
  endfunction

  always @(posedge clk) begin
    mA = modelStep(mA, rst, rowNA, 3);
    mB = modelStep(mB, rst, rowNB, 1);
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (validA === 1'b1) pulsesA++;
    if (mA.live) begin
      checkOutput("A.col_n", colNA, COL_SEL(2'(mA.col)));
      checkOutput("A.key_code", codeA, mA.code);
      checkOutput("A.key_valid", {3'b0, validA}, {3'b0, mA.valid});
      checkOutput("A.key_held", {3'b0, heldA}, {3'b0, mA.held});
    end
    if (mB.live) begin
      checkOutput("B.col_n", colNB, COL_SEL(2'(mB.col)));
      checkOutput("B.key_code", codeB, mB.code);
      checkOutput("B.key_valid", {3'b0, validB}, {3'b0, mB.valid});
      checkOutput("B.key_held", {3'b0, heldB}, {3'b0, mB.held});
    end
  end

  function automatic bit condMet(input int sel);
    case (sel)
      0: return validA === 1'b1;
      1: return heldA === 1'b0;
      2: return validB === 1'b1;
      3: return heldB === 1'b0;
      4: return colNA === 4'b1110;
      default: return (mA.cand >= 0) && !mA.locked && (mA.streak == 2);
    endcase
  endfunction

  task automatic waitUntil(input int sel, input int maxCyc, input string name);
    bit ok = 1'b0;
    for (int k = 0; k < maxCyc; k++) begin
      @(negedge clk);
      if (condMet(sel)) begin
        ok = 1'b1;
        break;
      end
    end
    compared++;
    if (!ok) begin
      mismatched++;
      $display("[TB] FAIL %s: event not seen within %0d cycles, required it", name, maxCyc);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input bit onA, input bit val);
    if (onA) pressA[r][c] = val;
    else     pressB[r][c] = val;
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] idle scan sequence");
    for (int j = 0; j < 20; j++) begin
      checkOutput("T1.col_n", colNA, COL_SEQ[(j / 4) % 4]);
      checkOutput("T1.key_valid", {3'b0, validA}, 4'h0);
      @(negedge clk);
    end

    $display("[TB] row1/col2 press and release");
    base = pulsesA;
    applyStimulus(1, 2, 1'b1, 1'b1);
    waitUntil(0, 200, "T2.valid_wait");
    checkOutput("T2.key_code", codeA, 4'b0110);
    checkOutput("T2.key_held", {3'b0, heldA}, 4'h1);
    repeat (20) @(negedge clk);
    checkOutput("T2.pulse_count", 4'(pulsesA - base), 4'h1);
    applyStimulus(1, 2, 1'b1, 1'b0);
    waitUntil(1, 100, "T4.release_wait");
    checkOutput("T4.col_n", colNA, 4'b0111);

    $display("[TB] bounced row0/col0 press");
    waitUntil(4, 100, "T3.col0_wait");
    base = pulsesA;
    applyStimulus(0, 0, 1'b1, 1'b1);
    repeat (SCAN) @(negedge clk);
    applyStimulus(0, 0, 1'b1, 1'b0);
    repeat (SCAN) @(negedge clk);
    applyStimulus(0, 0, 1'b1, 1'b1);
    repeat (60) @(negedge clk);
    checkOutput("T3.pulse_count", 4'(pulsesA - base), 4'h1);
    checkOutput("T3.key_code", codeA, 4'h0);
    applyStimulus(0, 0, 1'b1, 1'b0);
    waitUntil(1, 100, "T3.release_wait");

    $display("[TB] two rows in col1, then reset mid-debounce");
    applyStimulus(0, 1, 1'b1, 1'b1);
    applyStimulus(3, 1, 1'b1, 1'b1);
    waitUntil(0, 200, "T5.valid_wait");
    checkOutput("T5.key_code", codeA, 4'b0001);
    applyStimulus(0, 1, 1'b1, 1'b0);
    applyStimulus(3, 1, 1'b1, 1'b0);
    waitUntil(1, 100, "T5.release_wait");
    applyStimulus(0, 1, 1'b1, 1'b1);
    waitUntil(5, 200, "T5.debounce_wait");
    base = pulsesA;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("T5.rst_col_n", colNA, 4'b1110);
    checkOutput("T5.rst_key_code", codeA, 4'h0);
    checkOutput("T5.rst_key_valid", {3'b0, validA}, 4'h0);
    checkOutput("T5.rst_key_held", {3'b0, heldA}, 4'h0);
    applyStimulus(0, 1, 1'b1, 1'b0);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("T5.pulse_count", 4'(pulsesA - base), 4'h0);

    $display("[TB] single-scan debounce, row3/col3");
    applyStimulus(3, 3, 1'b0, 1'b1);
    waitUntil(2, 200, "T6.valid_wait");
    checkOutput("T6.key_code", codeB, 4'hF);
    checkOutput("T6.key_held", {3'b0, heldB}, 4'h1);
    applyStimulus(3, 3, 1'b0, 1'b0);
    waitUntil(3, 100, "T6.release_wait");
    repeat (8) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
